// File: rtl/fetch_unit_pkg.sv
// Shared defaults and state encoding for the fetch stage.
// FETCH_PERF_EN (optional) enables the fetch/flush performance counters.
package fetch_unit_pkg;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_INSTR_W  = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam int unsigned DEF_PC_STEP  = 1;
  localparam int unsigned PERF_W       = 32;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_OUT   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetched/flushed event counter pair.
// Only compiled when FETCH_PERF_EN is defined.
`ifdef FETCH_PERF_EN
module fetch_perf_counters
  import fetch_unit_pkg::*;
#(
  parameter int unsigned W = PERF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetched_evt,
  input  logic         flushed_evt,
  output logic [W-1:0] fetched_cnt,
  output logic [W-1:0] flushed_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_cnt <= '0;
      flushed_cnt <= '0;
    end else begin
      if (fetched_evt && (fetched_cnt != '1)) fetched_cnt <= fetched_cnt + W'(1);
      if (flushed_evt && (flushed_cnt != '1)) flushed_cnt <= flushed_cnt + W'(1);
    end
  end

endmodule
`endif

// File: rtl/fetch_unit.sv
// PC register and single-outstanding instruction fetch with branch redirect.
// Define FETCH_PERF_EN to add perf_fetched/perf_flushed counter outputs.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned       PC_STEP  = DEF_PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_fetched,
  output logic [PERF_W-1:0]  perf_flushed
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ack;

  // An ack with no request outstanding is a protocol violation and is ignored.
  assign ack         = imem_ack && imem_req;
  assign pc_seq      = pc + ADDR_W'(PC_STEP);
  assign redirect_pc = branch_en ? branch_addr : pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_req) begin
            // First cycle out of reset: nothing in flight, launch the request.
            pc        <= redirect_pc;
            imem_req  <= 1'b1;
            imem_addr <= redirect_pc;
          end else if (branch_en) begin
            pc <= branch_addr;
            if (ack) imem_addr <= branch_addr;
            else     state     <= S_DRAIN;
          end else if (ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            pc          <= pc_seq;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_OUT;
          end
        end

        S_OUT: begin
          // A redirect overrides a same-cycle handshake: the held word is wrong-path.
          if (branch_en || instr_ready) begin
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= redirect_pc;
            state       <= S_REQ;
          end
        end

        S_DRAIN: begin
          // Killed request keeps req/addr until ack; latest target wins.
          pc <= redirect_pc;
          if (ack) begin
            imem_addr <= redirect_pc;
            state     <= S_REQ;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetched_evt;
  logic flushed_evt;

  assign fetched_evt = instr_valid && instr_ready && !branch_en;
  assign flushed_evt = branch_en && (imem_req || instr_valid);

  fetch_perf_counters #(
    .W (PERF_W)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .fetched_evt (fetched_evt),
    .flushed_evt (flushed_evt),
    .fetched_cnt (perf_fetched),
    .flushed_cnt (perf_flushed)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        branch_en;
  logic [15:0] branch_addr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding request, held instruction, architectural PC.
  logic        m_req, m_valid, m_dead;
  logic [15:0] m_addr, m_pc, m_instr, m_ipc;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a);
    m_req  = 1'b1;
    m_addr = a;
    m_dead = 1'b0;
  endtask

  task automatic model_update(input logic ack, input logic br, input logic [15:0] ba, input logic rdy);
    if (m_valid) begin
      if (br) begin
        m_valid = 1'b0; m_pc = ba; issue(ba);
      end else if (rdy) begin
        m_valid = 1'b0; issue(m_pc);
      end
    end else if (!m_req) begin
      if (br) m_pc = ba;
      issue(m_pc);
    end else begin
      if (br) begin m_pc = ba; m_dead = 1'b1; end
      if (ack) begin
        if (m_dead) issue(m_pc);
        else begin
          m_req   = 1'b0;
          m_valid = 1'b1;
          m_instr = memf(m_addr);
          m_ipc   = m_addr;
          m_pc    = 16'(m_addr + 16'd1);
        end
      end
    end
  endtask

  task automatic sync_check();
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    if (m_valid) begin
      chk("instr", 32'(instr), 32'(m_instr));
      chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
    end
  endtask

  task automatic drive(input logic ack, input logic br, input logic [15:0] ba, input logic rdy);
    imem_ack    = ack;
    imem_rdata  = ack ? memf(imem_addr) : 16'($urandom);
    branch_en   = br;
    branch_addr = ba;
    instr_ready = rdy;
    model_update(ack, br, ba, rdy);
  endtask

  // Call right after a sync_check (or at time 0): reset lands before the next edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    imem_ack = 1'b0; branch_en = 1'b0; instr_ready = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_req = 1'b0; m_valid = 1'b0; m_dead = 1'b0;
    m_pc = 16'h0000; m_addr = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic fetch_one();
    sync_check(); drive(1'b1, 1'b0, 16'h0000, 1'b0);
    sync_check(); drive(1'b0, 1'b0, 16'h0000, 1'b1);
  endtask

  typedef struct {
    logic        ack;
    logic        br;
    logic [15:0] ba;
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_ipc;
  } vec_t;

  vec_t tab[17];
  int unsigned lat_left;
  logic        a;

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    branch_en = 1'b0; branch_addr = '0; instr_ready = 1'b0;

    // ack, br, ba, rdy | exp req, addr, valid, instr_pc
    tab[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tab[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tab[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000};
    tab[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
    tab[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
    tab[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002};
    tab[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000};
    tab[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003};
    tab[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000};
    tab[9]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004};
    tab[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000};
    tab[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0100};
    tab[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100};
    tab[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0101, 1'b0, 16'h0000};
    tab[14] = '{1'b1, 1'b1, 16'h0200, 1'b0, 1'b1, 16'h0101, 1'b0, 16'h0000};
    tab[15] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 1'b0, 16'h0000};
    tab[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0200};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      sync_check();
      chk($sformatf("tab%0d_req", i), 32'(imem_req), 32'(tab[i].e_req));
      if (tab[i].e_req) chk($sformatf("tab%0d_addr", i), 32'(imem_addr), 32'(tab[i].e_addr));
      chk($sformatf("tab%0d_valid", i), 32'(instr_valid), 32'(tab[i].e_valid));
      if (tab[i].e_valid) chk($sformatf("tab%0d_ipc", i), 32'(instr_pc), 32'(tab[i].e_ipc));
      drive(tab[i].ack, tab[i].br, tab[i].ba, tab[i].rdy);
    end

    // Slow memory and stalled decode at pc 5.
    sync_check();
    do_reset();
    for (int i = 0; i < 5; i++) fetch_one();
    for (int i = 0; i < 2; i++) begin
      sync_check(); chk("slow_addr5", 32'(imem_addr), 32'h5); drive(1'b0, 1'b0, 16'h0, 1'b0);
    end
    sync_check(); drive(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sync_check();
      chk("hold_pc5", 32'(instr_pc), 32'h5);
      chk("hold_no_req", 32'(imem_req), 32'd0);
      chk("hold_instr", 32'(instr), 32'(memf(16'h5)));
      drive(1'b0, 1'b0, 16'h0, 1'b0);
    end
    sync_check(); drive(1'b0, 1'b0, 16'h0, 1'b1);
    fetch_one();

    // Branch while request for 7 in flight, ack two cycles later.
    sync_check(); chk("br_addr7", 32'(imem_addr), 32'h7); drive(1'b0, 1'b1, 16'h0040, 1'b1);
    for (int i = 0; i < 2; i++) begin
      sync_check();
      chk("drain_addr7", 32'(imem_addr), 32'h7);
      chk("drain_no_valid", 32'(instr_valid), 32'd0);
      drive(i == 1, 1'b0, 16'h0, 1'b1);
    end
    sync_check();
    chk("after_drain_addr", 32'(imem_addr), 32'h0040);
    chk("after_drain_valid", 32'(instr_valid), 32'd0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    sync_check(); drive(1'b0, 1'b0, 16'h0, 1'b1);

    // Two redirects during one drain: latest wins.
    sync_check(); drive(1'b0, 1'b1, 16'h0020, 1'b0);
    sync_check(); drive(1'b0, 1'b1, 16'h0030, 1'b0);
    sync_check(); drive(1'b0, 1'b0, 16'h0, 1'b0);
    sync_check(); drive(1'b1, 1'b0, 16'h0, 1'b0);
    sync_check(); chk("latest_target", 32'(imem_addr), 32'h0030);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    sync_check(); drive(1'b0, 1'b0, 16'h0, 1'b1);

    // PC wrap at 0xFFFF.
    sync_check(); drive(1'b1, 1'b1, 16'hFFFF, 1'b0);
    sync_check(); chk("wrap_req_ffff", 32'(imem_addr), 32'hFFFF); drive(1'b1, 1'b0, 16'h0, 1'b0);
    sync_check(); chk("wrap_ipc", 32'(instr_pc), 32'hFFFF); drive(1'b0, 1'b0, 16'h0, 1'b1);
    sync_check(); chk("wrap_next", 32'(imem_addr), 32'h0000); drive(1'b0, 1'b1, 16'h1234, 1'b0);

    // Reset in the middle of a drain.
    sync_check(); chk("mid_drain_req", 32'(imem_req), 32'd1); drive(1'b0, 1'b0, 16'h0, 1'b0);
    sync_check();
    do_reset();
    sync_check();
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", 32'(imem_addr), 32'h0000);
    drive(1'b0, 1'b0, 16'h0, 1'b0);

    // Randomized traffic with variable latency and spurious acks.
    lat_left = 0;
    for (int c = 0; c < 4000; c++) begin
      sync_check();
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        lat_left = 0;
      end else begin
        if (imem_req) begin
          if (lat_left == 0) begin a = 1'b1; lat_left = $urandom_range(0, 3); end
          else begin a = 1'b0; lat_left--; end
        end else begin
          a = ($urandom_range(0, 7) == 0);
        end
        drive(a, $urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 1) == 1);
      end
    end
    sync_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
